// File: rtl/enha_sched_pkg.sv
// Shared types and widths for the enhancement-path block scheduler.
package enha_sched_pkg;

    localparam int unsigned BLK_DATA_W = 8;
    localparam int unsigned LINESUM_W  = 14;
    localparam int unsigned VCNT_W     = 7;
    localparam int unsigned BLK_IDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } schedState_t;

    typedef struct packed {
        logic [BLK_DATA_W-1:0] blockData;
        logic [LINESUM_W-1:0]  lineSum;
    } blkPayload_t;

endpackage

// File: rtl/enha_block_scheduler_if.sv
// Valid/ready channel from the block-average stage into the scheduler.
interface enha_block_scheduler_if;
    import enha_sched_pkg::*;

    logic                  iAvgValid;
    logic [BLK_DATA_W-1:0] iBlockData;
    logic [LINESUM_W-1:0]  iLineSum;
    logic                  oAvgReady;

    modport master (output iAvgValid, iBlockData, iLineSum, input oAvgReady);
    modport slave  (input iAvgValid, iBlockData, iLineSum, output oAvgReady);
endinterface

// File: rtl/enha_edge_det.sv
// Registered rise/fall pulse generator for a synchronous level input.
module enha_edge_det (
    input  logic clk,
    input  logic rstN,
    input  logic sig,
    output logic rise,
    output logic fall
);
    logic sigQ;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sigQ <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sigQ <= sig;
            rise <= sig & ~sigQ;
            fall <= ~sig & sigQ;
        end
    end
endmodule

// File: rtl/enha_block_scheduler.sv
// Holds one averaged block and issues it to the enhancement path during horizontal blanking.
// Optional ENHA_SCHED_FORCE_ISSUE_EN: force the issue after MAX_WAIT held cycles and flag it on oForced.
module enha_block_scheduler
    import enha_sched_pkg::*;
#(
    parameter int unsigned BLK_COLS      = 8,
    parameter int unsigned BLK_ROWS      = 6,
    parameter int unsigned LINES_PER_ROW = 90
`ifdef ENHA_SCHED_FORCE_ISSUE_EN
    , parameter int unsigned MAX_WAIT    = 255
`endif
) (
    input  logic                  iODCK,
    input  logic                  iRST,
    input  logic                  iV_Duty,
    input  logic                  iH_Duty,
    enha_block_scheduler_if.slave avg,
    output logic                  oWEA,
    output logic [BLK_DATA_W-1:0] oBlockData,
    output logic [LINESUM_W-1:0]  oLineSum,
    output logic [VCNT_W-1:0]     oV_Block_Duty_Count,
    output logic [BLK_IDX_W-1:0]  oBlkCol,
    output logic [BLK_IDX_W-1:0]  oBlkRow,
    output logic                  oFrameDone,
    output logic                  oUnderrun
`ifdef ENHA_SCHED_FORCE_ISSUE_EN
    , output logic                oForced
`endif
);

    schedState_t          state;
    blkPayload_t          hold;
    logic                 holdFull;
    logic [BLK_IDX_W-1:0] col;
    logic [BLK_IDX_W-1:0] row;
    logic                 vRise, vFall, hFall, hRiseUnused;
    logic                 accept, issue, lastBlk, forceNow;

    enha_edge_det uVEdge (.clk(iODCK), .rstN(iRST), .sig(iV_Duty), .rise(vRise), .fall(vFall));
    enha_edge_det uHEdge (.clk(iODCK), .rstN(iRST), .sig(iH_Duty), .rise(hRiseUnused), .fall(hFall));

    assign avg.oAvgReady = (state == ACTIVE) && !holdFull;
    assign accept        = avg.iAvgValid && avg.oAvgReady;
    assign issue         = (state == ACTIVE) && holdFull && (!iH_Duty || forceNow);
    assign lastBlk       = (col == BLK_IDX_W'(BLK_COLS - 1)) && (row == BLK_IDX_W'(BLK_ROWS - 1));

`ifdef ENHA_SCHED_FORCE_ISSUE_EN
    localparam int unsigned WAIT_W = 10;
    logic [WAIT_W-1:0] waitCnt;

    assign forceNow = (waitCnt == WAIT_W'(MAX_WAIT));

    // Counts only cycles where a full hold register is blocked by active video.
    always_ff @(posedge iODCK or negedge iRST) begin
        if (!iRST) begin
            waitCnt <= '0;
        end else if (issue || !holdFull || (state != ACTIVE)) begin
            waitCnt <= '0;
        end else if (iH_Duty) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end
`else
    assign forceNow = 1'b0;
`endif

    always_ff @(posedge iODCK or negedge iRST) begin
        if (!iRST) begin
            state               <= IDLE;
            hold                <= '0;
            holdFull            <= 1'b0;
            col                 <= '0;
            row                 <= '0;
            oWEA                <= 1'b0;
            oBlockData          <= '0;
            oLineSum            <= '0;
            oV_Block_Duty_Count <= '0;
            oBlkCol             <= '0;
            oBlkRow             <= '0;
            oFrameDone          <= 1'b0;
            oUnderrun           <= 1'b0;
`ifdef ENHA_SCHED_FORCE_ISSUE_EN
            oForced             <= 1'b0;
`endif
        end else begin
            oWEA       <= 1'b0;
`ifdef ENHA_SCHED_FORCE_ISSUE_EN
            oForced    <= 1'b0;
`endif
            // Frame-done pulse follows the cycle that presented the final block.
            oFrameDone <= oWEA && (oBlkCol == BLK_IDX_W'(BLK_COLS - 1))
                               && (oBlkRow == BLK_IDX_W'(BLK_ROWS - 1));

            if (hFall && (state != IDLE)) begin
                oV_Block_Duty_Count <= (oV_Block_Duty_Count == VCNT_W'(LINES_PER_ROW - 1))
                                       ? '0 : oV_Block_Duty_Count + 1'b1;
            end

            if (accept) begin
                hold.blockData <= avg.iBlockData;
                hold.lineSum   <= avg.iLineSum;
                holdFull       <= 1'b1;
            end

            if (issue) begin
                oWEA       <= 1'b1;
                oBlockData <= hold.blockData;
                oLineSum   <= hold.lineSum;
                oBlkCol    <= col;
                oBlkRow    <= row;
                holdFull   <= 1'b0;
`ifdef ENHA_SCHED_FORCE_ISSUE_EN
                oForced    <= iH_Duty;
`endif
                if (col == BLK_IDX_W'(BLK_COLS - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            // A frame end arriving with the final issue still counts as complete.
            case (state)
                IDLE: begin
                    if (vRise) begin
                        state               <= ACTIVE;
                        col                 <= '0;
                        row                 <= '0;
                        oV_Block_Duty_Count <= '0;
                        oUnderrun           <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (vFall) begin
                        state    <= IDLE;
                        holdFull <= 1'b0;
                        if (!(issue && lastBlk)) oUnderrun <= 1'b1;
                    end else if (issue && lastBlk) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (vFall) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_enha_block_scheduler.sv
// Self-checking bench for enha_block_scheduler: vector table, random blocks, frame corner cases.
module tb_enha_block_scheduler;
    localparam int COLS  = 8;
    localparam int ROWS  = 6;
    localparam int LINES = 90;
`ifdef ENHA_SCHED_FORCE_ISSUE_EN
    localparam int MW = 4;
    logic oForced;
`endif

    logic        iODCK = 1'b0;
    logic        iRST;
    logic        iV_Duty;
    logic        iH_Duty;
    logic        oWEA;
    logic [7:0]  oBlockData;
    logic [13:0] oLineSum;
    logic [6:0]  oV_Block_Duty_Count;
    logic [3:0]  oBlkCol;
    logic [3:0]  oBlkRow;
    logic        oFrameDone;
    logic        oUnderrun;

    int checks = 0;
    int errors = 0;
    int weaCount = 0;
    int weaBase;

    enha_block_scheduler_if avgIf ();

    enha_block_scheduler #(
        .BLK_COLS(COLS), .BLK_ROWS(ROWS), .LINES_PER_ROW(LINES)
`ifdef ENHA_SCHED_FORCE_ISSUE_EN
        , .MAX_WAIT(MW)
`endif
    ) dut (
        .iODCK(iODCK), .iRST(iRST), .iV_Duty(iV_Duty), .iH_Duty(iH_Duty),
        .avg(avgIf),
        .oWEA(oWEA), .oBlockData(oBlockData), .oLineSum(oLineSum),
        .oV_Block_Duty_Count(oV_Block_Duty_Count),
        .oBlkCol(oBlkCol), .oBlkRow(oBlkRow),
        .oFrameDone(oFrameDone), .oUnderrun(oUnderrun)
`ifdef ENHA_SCHED_FORCE_ISSUE_EN
        , .oForced(oForced)
`endif
    );

    always #5 iODCK = ~iODCK;

    // Independent tally of write strobes, sampled mid-cycle.
    always @(negedge iODCK) if (oWEA === 1'b1) weaCount++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  d;
        logic [13:0] s;
        int          hWait;
        int          col;
        int          row;
    } vec_t;
    vec_t tbl[8];

    task automatic tick();
        @(posedge iODCK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One block through the scheduler; video stays active for hWait edges after the accept.
    task automatic doBlock(input logic [7:0] d, input logic [13:0] s, input int hWait,
                           input int expCol, input int expRow);
        int lat;
        int expLat;
        bit seen;
        bit stallOk;
        check("readyBeforeAccept", avgIf.oAvgReady, 1);
        avgIf.iAvgValid  = 1'b1;
        avgIf.iBlockData = d;
        avgIf.iLineSum   = s;
        tick();
        check("readyWhileHeld", avgIf.oAvgReady, 0);
        // Producer keeps offering different data; it must stay stalled.
        avgIf.iBlockData = ~d;
        avgIf.iLineSum   = ~s;
        lat = 0; seen = 1'b0; stallOk = 1'b1;
        while (!seen && lat < 64) begin
            iH_Duty = (lat < hWait);
            tick();
            lat++;
            if (oWEA) seen = 1'b1;
            else if (avgIf.oAvgReady) stallOk = 1'b0;
        end
        avgIf.iAvgValid = 1'b0;
        iH_Duty = 1'b0;
        expLat = hWait + 1;
`ifdef ENHA_SCHED_FORCE_ISSUE_EN
        if (expLat > MW + 1) expLat = MW + 1;
        check("forced", oForced, (hWait > MW));
`endif
        check("issueSeen", seen, 1);
        check("latency", lat, expLat);
        check("stall", stallOk, 1);
        check("blockData", oBlockData, d);
        check("lineSum", oLineSum, s);
        check("blkCol", oBlkCol, expCol);
        check("blkRow", oBlkRow, expRow);
    endtask

    task automatic runBlocks(input int first, input int n, input int maxWait);
        for (int i = first; i < first + n; i++) begin
            doBlock(8'($urandom), 14'($urandom), int'($urandom_range(maxWait, 0)), i % COLS, i / COLS);
        end
    endtask

    task automatic startFrame();
        iV_Duty = 1'b1;
        tick();
        tick();
        weaBase = weaCount;
        check("frameStartReady", avgIf.oAvgReady, 1);
        check("frameStartVcnt", oV_Block_Duty_Count, 0);
        check("frameStartUnderrun", oUnderrun, 0);
    endtask

    task automatic hPulse();
        iH_Duty = 1'b1; tick(); tick();
        iH_Duty = 1'b0; tick(); tick();
    endtask

    initial begin
        tbl[0] = '{8'h5A, 14'h1234, 0,  0, 0};
        tbl[1] = '{8'hA5, 14'h0001, 20, 1, 0};
        tbl[2] = '{8'h00, 14'h0000, 1,  2, 0};
        tbl[3] = '{8'hFF, 14'h3FFF, 3,  3, 0};
        tbl[4] = '{8'h11, 14'h2222, 4,  4, 0};
        tbl[5] = '{8'h7E, 14'h1ABC, 2,  5, 0};
        tbl[6] = '{8'hC3, 14'h0F0F, 5,  6, 0};
        tbl[7] = '{8'h3C, 14'h3000, 0,  7, 0};

        iRST = 1'b0; iV_Duty = 1'b0; iH_Duty = 1'b0;
        avgIf.iAvgValid = 1'b0; avgIf.iBlockData = '0; avgIf.iLineSum = '0;
        tick(); tick();
        check("rstWEA", oWEA, 0);
        check("rstReady", avgIf.oAvgReady, 0);
        check("rstUnderrun", oUnderrun, 0);
        check("rstFrameDone", oFrameDone, 0);
        iRST = 1'b1;
        tick(); tick();
        check("idleReady", avgIf.oAvgReady, 0);

        // Frame 1: complete 8x6 frame.
        startFrame();
        for (int i = 0; i < 8; i++) doBlock(tbl[i].d, tbl[i].s, tbl[i].hWait, tbl[i].col, tbl[i].row);
        runBlocks(8, COLS * ROWS - 8, 7);
        tick();
        check("frameDonePulse", oFrameDone, 1);
        check("doneReady", avgIf.oAvgReady, 0);
        check("doneUnderrun", oUnderrun, 0);
        avgIf.iAvgValid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("doneStillNotReady", avgIf.oAvgReady, 0);
        check("frameDoneSingle", oFrameDone, 0);
        check("frame1Strobes", weaCount - weaBase, COLS * ROWS);
        avgIf.iAvgValid = 1'b0;
        iV_Duty = 1'b0;
        tick(); tick(); tick();

        // Frame 2: ends early with one block still held.
        startFrame();
        runBlocks(0, 30, 2);
        avgIf.iAvgValid = 1'b1; avgIf.iBlockData = 8'hEE; iH_Duty = 1'b1;
        tick();
        avgIf.iAvgValid = 1'b0;
        iV_Duty = 1'b0;
        tick(); tick(); tick();
        iH_Duty = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("underrunSet", oUnderrun, 1);
        check("underrunReady", avgIf.oAvgReady, 0);
        check("underrunStrobes", weaCount - weaBase, 30);
        check("underrunNoFrameDone", oFrameDone, 0);

        // Frame 3: frame end coincides with the final issue.
        startFrame();
        runBlocks(0, COLS * ROWS - 1, 3);
        avgIf.iAvgValid = 1'b1; avgIf.iBlockData = 8'h9C; avgIf.iLineSum = 14'h02A5;
        iV_Duty = 1'b0;
        tick();
        avgIf.iAvgValid = 1'b0;
        tick();
        check("lastWEA", oWEA, 1);
        check("lastData", oBlockData, 8'h9C);
        check("lastCol", oBlkCol, COLS - 1);
        check("lastRow", oBlkRow, ROWS - 1);
        tick();
        check("coincFrameDone", oFrameDone, 1);
        check("coincUnderrun", oUnderrun, 0);
        check("coincReady", avgIf.oAvgReady, 0);

        // Frame 4: asynchronous reset with a block held and col=3.
        startFrame();
        runBlocks(0, 4, 1);
        check("preRstCol", oBlkCol, 3);
        avgIf.iAvgValid = 1'b1; avgIf.iBlockData = 8'h44; iH_Duty = 1'b1;
        tick();
        avgIf.iAvgValid = 1'b0;
        #2 iRST = 1'b0;
        #1;
        check("asyncRstCol", oBlkCol, 0);
        check("asyncRstData", oBlockData, 0);
        check("asyncRstSum", oLineSum, 0);
        check("asyncRstReady", avgIf.oAvgReady, 0);
        check("asyncRstWEA", oWEA, 0);
        iV_Duty = 1'b0; iH_Duty = 1'b0;
        #2 iRST = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("postRstNoWEA", oWEA, 0);
        check("postRstReady", avgIf.oAvgReady, 0);

        // Frame 5: line-within-block-row counter and wrap.
        startFrame();
        for (int i = 0; i < LINES - 1; i++) hPulse();
        check("vcnt89", oV_Block_Duty_Count, LINES - 1);
        hPulse();
        check("vcntWrap", oV_Block_Duty_Count, 0);
        for (int i = 0; i < 7; i++) hPulse();
        check("vcnt7", oV_Block_Duty_Count, 7);
        iV_Duty = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/enha_block_scheduler.md
Name: enha_block_scheduler

Overview:
Sequences per-block transfers from the block-average stage into the enhancement path (the buffer, variance maker and selector chain).
- Accepts one averaged block at a time from the average stage over a valid/ready handshake.
- Issues it to the enhancement path as a single-cycle write strobe, only during horizontal blanking.
- Tracks block column/row, the line-within-block-row count (V block duty count) and frame completion.

Parameters:
BLK_COLS, 8, blocks per block row (2..16)
BLK_ROWS, 6, block rows per frame (2..16)
LINES_PER_ROW, 90, active lines per block row (2..127)
MAX_WAIT, 255, hold-cycle limit for the optional forced issue (1..1023)

Ports:
iODCK  in  1  pixel clock
iRST  in  1  reset, asynchronous, active-low
iV_Duty  in  1  vertical active window
iH_Duty  in  1  horizontal active window (high = active pixels)
iAvgValid  in  1  average stage presents a block
iBlockData  in  8  block average value
iLineSum  in  14  line-sum average for the block
oAvgReady  out  1  scheduler can accept a block
oWEA  out  1  one-cycle write strobe to enhancement path
oBlockData  out  8  block value, valid with oWEA
oLineSum  out  14  line sum, valid with oWEA
oV_Block_Duty_Count  out  7  line index within current block row
oBlkCol  out  4  column of the block issued with oWEA
oBlkRow  out  4  row of the block issued with oWEA
oFrameDone  out  1  one-cycle pulse after the last block of the frame issues
oUnderrun  out  1  sticky: frame ended before BLK_COLS*BLK_ROWS blocks issued

Behaviour:
- Reset (iRST=0, asynchronous): every output is 0, the hold register is empty, all counters are 0, and the state is IDLE.
- FSM states: IDLE, ACTIVE, DONE.
  - IDLE -> ACTIVE on the iV_Duty rising edge (registered edge detect). On entry: clear counters, clear oUnderrun.
  - ACTIVE -> DONE on the clock edge that issues the block with index BLK_COLS*BLK_ROWS-1. oFrameDone pulses in the following cycle.
  - ACTIVE -> IDLE on an iV_Duty falling edge with an incomplete count. That edge sets oUnderrun and discards the hold register.
  - DONE -> IDLE on the iV_Duty falling edge.
- oAvgReady is combinational: state==ACTIVE && hold empty. A transfer occurs on the edge where iAvgValid && oAvgReady; it loads iBlockData and iLineSum into the hold register.
- Issue rule:
  - On an edge where the hold register is full and iH_Duty==0: register oWEA=1 with the hold contents and the current col/row, then empty the hold.
  - oWEA is low in every other cycle. Output data holds its last value when oWEA is low.
- Timing:
  - Minimum latency is one cycle from the accept edge to oWEA high.
  - Maximum throughput is one block per 2 cycles, because oAvgReady is low while the hold register is full.
  - A hold register that is full while iH_Duty==1 waits; no data is lost and the producer stalls.
- Column/row counters: oBlkCol increments on each issue and wraps at BLK_COLS-1 -> 0, at which point oBlkRow increments. No wrap beyond BLK_ROWS; DONE is entered instead.
- Line counting: oV_Block_Duty_Count increments on each iH_Duty falling edge while ACTIVE or DONE, and wraps at LINES_PER_ROW-1 -> 0. It is cleared on the iV_Duty rising edge.
- Simultaneous events:
  - An iV_Duty falling edge coinciding with an issue edge: the issue completes first, then the completion check runs. It sets oUnderrun only if the count is still incomplete.
  - An iV_Duty rising edge while in DONE (no falling edge seen): ignored.
- DONE or IDLE: oAvgReady=0, so extra producer blocks are stalled, not dropped.
- oUnderrun stays set through IDLE until the next frame start.

Optional Feature:
ENHA_SCHED_FORCE_ISSUE_EN
- Defined:
  - A 10-bit wait counter counts cycles in which the hold register is full and iH_Duty==1. It clears on issue.
  - When the counter reaches MAX_WAIT, the block issues on the next edge regardless of iH_Duty.
  - Adds output oForced (1 bit), pulsing together with such an oWEA.
- Undefined: no counter and no oForced port; the block issues only during blanking.

Decomposition:
- Package enha_sched_pkg holds:
  - the state enum (IDLE/ACTIVE/DONE);
  - the widths BLK_DATA_W=8, LINESUM_W=14, VCNT_W=7, BLK_IDX_W=4.
- Sub-module enha_edge_det: registered rise/fall pulses for iV_Duty and iH_Duty, instantiated twice.

Test Plan:
1. Reset mid-frame: hold full, col=3, then iRST=0 -> all outputs 0 immediately (asynchronous), oAvgReady=0.
2. Single block:
   - Stimulus: iV_Duty rises; iAvgValid with data 0x5A, sum 0x1234; iH_Duty=0.
   - Response: oWEA high one cycle later with 0x5A/0x1234, col=0, row=0; oAvgReady low for that cycle.
3. Blanking hold:
   - Stimulus: accept while iH_Duty=1 for 20 cycles.
   - Response: no oWEA until the first cycle after iH_Duty falls; data intact; iAvgValid stalled.
4. Full frame with 8x6 defaults:
   - Response: 48 oWEA pulses; col wraps 7->0 with row increment; oFrameDone one cycle after the 48th; oAvgReady=0 in DONE; oUnderrun=0.
5. Underrun: iV_Duty falls after 30 issues -> oUnderrun=1, state IDLE; next iV_Duty rise clears it.
6. With ENHA_SCHED_FORCE_ISSUE_EN and MAX_WAIT=4: hold full with iH_Duty=1 -> oWEA and oForced pulse after 4 wait cycles. Also check oV_Block_Duty_Count wraps 89->0 over 90 iH_Duty falls.
